// File: rtl/hesap_cekirdegi.sv
// Shared multi-cycle arithmetic core: add/sub in one step, shift-add multiply,
// restoring divide and two-bits-per-cycle integer square root.
module hesap_cekirdegi #(
   parameter int GENISLIK = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    basla,
   input  logic [GENISLIK-1:0]     sayi1,
   input  logic [GENISLIK-1:0]     sayi2,
   input  logic [2:0]              tur,
   output logic [2*GENISLIK-1:0]   sonuc,
   output logic                    hazir,
   output logic                    gecerli,
   output logic                    tasma
);

   localparam int W  = GENISLIK;
   localparam int CW = $clog2(W + 1);

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_MUL  = 3'b010;
   localparam logic [2:0] OP_DIV  = 3'b011;
   localparam logic [2:0] OP_SQRT = 3'b100;

   typedef enum logic {BOS, HESAP} durum_e;

   durum_e          durum_q, durum_d;
   logic [W-1:0]    a_q, a_d, b_q, b_d;
   logic [2:0]      op_q, op_d;
   logic [CW-1:0]   cnt_q, cnt_d, son_idx;
   logic [2*W-1:0]  acc_q, acc_d;
   logic [W-1:0]    kalan_q, kalan_d;
   logic [2*W-1:0]  sonuc_q, sonuc_d;
   logic            gecerli_q, gecerli_d, tasma_q, tasma_d;

   // One-iteration step of each multi-cycle algorithm, all sharing acc_q.
   logic [W:0]      mul_sum, div_t;
   logic [2*W-1:0]  mul_next, div_next, sq_next;
   logic            div_ge, sq_ge;
   logic [W+1:0]    sq_sh, sq_trial;
   logic [W-1:0]    sq_kalan, sq_root;
   logic [W-1:0]    add_s, sub_s;
   logic            add_ov, sub_ov;

   always_comb begin
      mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, a_q} : '0);
      mul_next = {mul_sum, acc_q[W-1:1]};

      div_t    = {acc_q[2*W-1:W], acc_q[W-1]};
      div_ge   = div_t >= {1'b0, b_q};
      div_next = {(div_ge ? W'(div_t - {1'b0, b_q}) : W'(div_t)), acc_q[W-2:0], div_ge};

      // acc_q holds {root, radicand shifted left}; kalan_q is the running remainder.
      sq_sh    = {kalan_q, acc_q[W-1:W-2]};
      sq_trial = {acc_q[2*W-1:W], 2'b01};
      sq_ge    = sq_sh >= sq_trial;
      sq_kalan = sq_ge ? W'(sq_sh - sq_trial) : W'(sq_sh);
      sq_root  = {acc_q[2*W-2:W], sq_ge};
      sq_next  = {sq_root, acc_q[W-3:0], 2'b00};

      add_s  = a_q + b_q;
      sub_s  = a_q - b_q;
      add_ov = (a_q[W-1] == b_q[W-1]) && (add_s[W-1] != a_q[W-1]);
      sub_ov = (a_q[W-1] != b_q[W-1]) && (sub_s[W-1] != a_q[W-1]);

      case (op_q)
         OP_MUL:  son_idx = CW'(W - 1);
         OP_DIV:  son_idx = (b_q == '0) ? '0 : CW'(W - 1);
         OP_SQRT: son_idx = CW'(W / 2 - 1);
         default: son_idx = '0;
      endcase
   end

   // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
   always_comb begin
      durum_d   = durum_q;
      a_d       = a_q;
      b_d       = b_q;
      op_d      = op_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      kalan_d   = kalan_q;
      sonuc_d   = sonuc_q;
      gecerli_d = gecerli_q;
      tasma_d   = tasma_q;

      case (durum_q)
         BOS: begin
            if (basla) begin
               durum_d   = HESAP;
               a_d       = sayi1;
               b_d       = sayi2;
               op_d      = tur;
               cnt_d     = '0;
               acc_d     = {{W{1'b0}}, (tur == OP_MUL) ? sayi2 : sayi1};
               kalan_d   = '0;
               gecerli_d = 1'b0;
               tasma_d   = 1'b0;
            end
         end
         HESAP: begin
            cnt_d = cnt_q + CW'(1);
            case (op_q)
               OP_MUL:  acc_d = mul_next;
               OP_DIV:  acc_d = div_next;
               OP_SQRT: begin
                  acc_d   = sq_next;
                  kalan_d = sq_kalan;
               end
               default: ;
            endcase
            if (cnt_q == son_idx) begin
               durum_d   = BOS;
               sonuc_d   = '0;
               gecerli_d = 1'b1;
               tasma_d   = 1'b0;
               case (op_q)
                  OP_ADD: begin
                     sonuc_d = {{W{add_s[W-1]}}, add_s};
                     tasma_d = add_ov;
                  end
                  OP_SUB: begin
                     sonuc_d = {{W{sub_s[W-1]}}, sub_s};
                     tasma_d = sub_ov;
                  end
                  OP_MUL: begin
                     sonuc_d = mul_next;
                     tasma_d = |mul_next[2*W-1:W];
                  end
                  OP_DIV: begin
                     if (b_q == '0) begin
                        gecerli_d = 1'b0;
                        tasma_d   = 1'b1;
                     end else begin
                        sonuc_d = div_next;
                     end
                  end
                  OP_SQRT: sonuc_d = {sq_kalan, sq_root};
                  default: gecerli_d = 1'b0;
               endcase
            end
         end
         default: durum_d = BOS;
      endcase
   end

   // NOTE: non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         durum_q   <= BOS;
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= '0;
         cnt_q     <= '0;
         acc_q     <= '0;
         kalan_q   <= '0;
         sonuc_q   <= '0;
         gecerli_q <= 1'b0;
         tasma_q   <= 1'b0;
      end else begin
         durum_q   <= durum_d;
         a_q       <= a_d;
         b_q       <= b_d;
         op_q      <= op_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         kalan_q   <= kalan_d;
         sonuc_q   <= sonuc_d;
         gecerli_q <= gecerli_d;
         tasma_q   <= tasma_d;
      end
   end

   assign sonuc   = sonuc_q;
   assign hazir   = (durum_q == BOS);
   assign gecerli = gecerli_q;
   assign tasma   = tasma_q;

endmodule

// File: doc/hesap_cekirdegi.md
# hesap_cekirdegi

Parametrised sequential arithmetic core for the calculator. It accepts two operands and an operation code through a start/ready handshake, then computes add, subtract, multiply, divide or integer square root over a configurable word width. It returns a double-width result with valid and overflow flags. It sits under the calculator top level and replaces per-operation submodule calls with a single multi-cycle datapath shared by all operations.

## Interface
- GENISLIK, 32, operand width in bits; must be even and ≥ 4
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  reset, asynchronous and active-low
- basla  input  1  start request; accepted only while hazir=1
- sayi1  input  GENISLIK  operand A (dividend, radicand)
- sayi2  input  GENISLIK  operand B (divisor); ignored for square root
- tur  input  3  operation: 000 add, 001 sub, 010 mul, 011 div, 100 sqrt, 101–111 invalid
- sonuc  output  2*GENISLIK  result; holds its value until the next accepted basla completes
- hazir  output  1  1 = idle, can accept basla; 0 = busy
- gecerli  output  1  1 = sonuc holds a valid result of the last operation
- tasma  output  1  overflow / out-of-range flag of the last operation

## Operation
- States:
  - BOS (idle, hazir=1)
  - HESAP (busy, hazir=0; iteration counter active)
- BOS → HESAP on a rising edge with basla=1:
  - sayi1, sayi2 and tur are latched into internal registers.
  - gecerli and tasma are cleared.
  - Inputs are don't-care after acceptance.
- HESAP → BOS when the counter reaches the operation's latency L. On that edge sonuc, gecerli and tasma are written and hazir returns to 1.
- basla while busy (hazir=0) is ignored; no queueing.
- Add/sub (signed two's complement):
  - Low GENISLIK bits hold the wrapped sum/difference; upper half is its sign extension.
  - tasma = signed overflow; gecerli = 1.
- Mul (unsigned, shift-add, one partial product per cycle):
  - sonuc = full 2*GENISLIK product.
  - tasma = 1 if upper half ≠ 0; gecerli = 1.
- Div (unsigned restoring, one quotient bit per cycle):
  - sonuc[GENISLIK-1:0] = quotient; sonuc[2*GENISLIK-1:GENISLIK] = remainder.
  - tasma = 0; gecerli = 1.
- Div with sayi2 = 0: completes with L = 1; sonuc = 0, gecerli = 0, tasma = 1.
- Sqrt (bit-by-bit, two radicand bits per cycle), operand sayi1 only:
  - Low half = floor(sqrt(sayi1)); upper half = sayi1 − root².
  - tasma = 0; gecerli = 1.
- Invalid tur (101–111): completes with L = 1; sonuc = 0, gecerli = 0, tasma = 0.

## Timing
- Reset (rst=0, asynchronous, any state, including mid-operation): state BOS, sonuc=0, hazir=1, gecerli=0, tasma=0. The operation in progress is abandoned and produces no result.
- Release of rst is synchronous to clk. basla on the first rising edge after release is accepted.
- Latency L, counted in rising edges from the accepting edge to the edge that raises hazir:
  - add/sub/invalid/div-by-zero: 1
  - mul: GENISLIK
  - div: GENISLIK
  - sqrt: GENISLIK/2
- Back-to-back operation: basla may be high on the same edge at which hazir is observed high. Throughput = L+1 cycles per operation minimum.
- basla held high continuously: a new operation starts on every edge at which the core is in BOS.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset/idle: assert rst low mid-operation at any cycle → sonuc=0, hazir=1, gecerli=0, tasma=0 immediately, with no clk edge needed; next basla is accepted normally.
- Add overflow (GENISLIK=32): tur=000, sayi1=0x7FFFFFFF, sayi2=1 → after 1 edge: sonuc=0xFFFFFFFF_80000000, tasma=1, gecerli=1. Sub check: 5−7 → sonuc=0xFFFFFFFF_FFFFFFFE, tasma=0.
- Mul: 0xFFFFFFFF × 0xFFFFFFFF → hazir low for 32 edges, then sonuc=0xFFFFFFFE_00000001, tasma=1; 3×4 → sonuc=12, tasma=0.
- Div: 100/7 → after 32 edges: sonuc low=14, high=2, gecerli=1; 5/0 → after 1 edge: gecerli=0, tasma=1, sonuc=0.
- Sqrt: sayi1=1000 → after 16 edges: low=31, high=39; sayi1=0xFFFFFFFF → low=0xFFFF, high=0x1FFFE.
- Handshake: pulse basla during busy mul → ignored, result unchanged. tur=111 → gecerli=0 after 1 edge. basla held high across two operations → second starts on the edge hazir is observed high.
